// File: rtl/gmii_pkg.sv
// Shared types and constants for the GMII transmit framer.
// Holds the FSM state encoding, framing bytes and CRC-32 parameters.
package gmii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    DRAIN,
    IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam logic [5:0]  MIN_PAYLOAD   = 6'd60;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_XOR       = 32'hFFFF_FFFF;

  function automatic logic [31:0] refl32(
    input logic [31:0] v
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 step over one byte.
// Ports: crc_i current register, data_i byte, crc_o next register.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_R = refl32(CRC_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ POLY_R;
      else      c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, pad, FCS and IFG.
// Ports: clk_125M/rst_n, s_* byte stream in, gm_tx_* GMII out, busy, frame_cnt.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter bit PAD_EN     = 1'b1
) (
  input  logic        clk_125M,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  gm_tx_d,
  output logic        gm_tx_en,
  output logic        gm_tx_err,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  // First preamble byte leaves on the IDLE exit edge,
  // so PREAMBLE itself issues the remaining six.
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 2);
  localparam logic [5:0] IFG_LAST = 6'(IFG_CYCLES - 1);

  state_t      st_q, st_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  tx_d_q, tx_d_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_err_q, tx_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [7:0]  crc_in;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;
  logic [5:0]  byte_inc;
  logic [7:0]  fcs_byte;

  // Pad bytes feed zeros into the CRC.
  assign crc_in = (st_q == DATA) ? s_data : 8'h00;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_in),
    .crc_o  (crc_next)
  );

  assign fcs_word = crc_q ^ CRC_XOR;
  assign byte_inc = (byte_cnt_q == MIN_PAYLOAD) ?
                    byte_cnt_q : byte_cnt_q + 6'd1;

  always_comb begin
    fcs_byte = fcs_word[7:0];
    unique case (cnt_q[1:0])
      2'd0: fcs_byte = fcs_word[7:0];
      2'd1: fcs_byte = fcs_word[15:8];
      2'd2: fcs_byte = fcs_word[23:16];
      2'd3: fcs_byte = fcs_word[31:24];
    endcase
  end

  always_comb begin
    st_d        = st_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    tx_d_d      = 8'h00;
    tx_en_d     = 1'b0;
    tx_err_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    unique case (st_q)
      IDLE: begin
        crc_d      = CRC_INIT;
        byte_cnt_d = 6'd0;
        cnt_d      = 6'd0;
        if (s_valid) begin
          st_d    = PREAMBLE;
          tx_d_d  = PREAMBLE_BYTE;
          tx_en_d = 1'b1;
        end
      end
      PREAMBLE: begin
        tx_d_d  = PREAMBLE_BYTE;
        tx_en_d = 1'b1;
        if (cnt_q == PRE_LAST) begin
          st_d  = SFD;
          cnt_d = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      SFD: begin
        tx_d_d  = SFD_BYTE;
        tx_en_d = 1'b1;
        st_d    = DATA;
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (s_valid) begin
          tx_d_d     = s_data;
          crc_d      = crc_next;
          byte_cnt_d = byte_inc;
          if (s_last) begin
            if (PAD_EN && (byte_inc < MIN_PAYLOAD)) st_d = PAD;
            else                                    st_d = FCS;
          end
        end else begin
          // Source starved mid-frame: poison it.
          tx_err_d = 1'b1;
          st_d     = DRAIN;
        end
      end
      PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_next;
        byte_cnt_d = byte_inc;
        if (byte_inc == MIN_PAYLOAD) st_d = FCS;
      end
      FCS: begin
        tx_d_d  = fcs_byte;
        tx_en_d = 1'b1;
        if (cnt_q[1:0] == 2'd3) begin
          st_d        = IFG;
          cnt_d       = 6'd0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          st_d  = IFG;
          cnt_d = 6'd0;
        end
      end
      IFG: begin
        if (cnt_q == IFG_LAST) begin
          st_d  = IDLE;
          cnt_d = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_125M or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      cnt_q       <= 6'd0;
      byte_cnt_q  <= 6'd0;
      crc_q       <= CRC_INIT;
      tx_d_q      <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_err_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      tx_d_q      <= tx_d_d;
      tx_en_q     <= tx_en_d;
      tx_err_q    <= tx_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready   = (st_q == DATA) || (st_q == DRAIN);
  assign busy      = (st_q != IDLE);
  assign gm_tx_d   = tx_d_q;
  assign gm_tx_en  = tx_en_q;
  assign gm_tx_err = tx_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer.
// Two instances: u_dut0 without padding, u_dut1 with padding.
module tb_gmii_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        sel0 = 1'b0;

  logic        rdy0, en0, err0, busy0;
  logic [7:0]  d0;
  logic [15:0] fc0;
  logic        rdy1, en1, err1, busy1;
  logic [7:0]  d1;
  logic [15:0] fc1;

  logic        obs_ready, obs_en, obs_err, obs_busy;
  logic [7:0]  obs_d;
  logic [15:0] obs_fc;

  int checks = 0;
  int failures = 0;

  always #4 clk = ~clk;

  gmii_tx_framer #(.IFG_CYCLES(12), .PAD_EN(1'b0)) u_dut0 (
    .clk_125M  (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid & sel0),
    .s_last    (s_last),
    .s_ready   (rdy0),
    .gm_tx_d   (d0),
    .gm_tx_en  (en0),
    .gm_tx_err (err0),
    .busy      (busy0),
    .frame_cnt (fc0)
  );

  gmii_tx_framer #(.IFG_CYCLES(12), .PAD_EN(1'b1)) u_dut1 (
    .clk_125M  (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid & ~sel0),
    .s_last    (s_last),
    .s_ready   (rdy1),
    .gm_tx_d   (d1),
    .gm_tx_en  (en1),
    .gm_tx_err (err1),
    .busy      (busy1),
    .frame_cnt (fc1)
  );

  assign obs_ready = sel0 ? rdy0 : rdy1;
  assign obs_en    = sel0 ? en0 : en1;
  assign obs_err   = sel0 ? err0 : err1;
  assign obs_busy  = sel0 ? busy0 : busy1;
  assign obs_d     = sel0 ? d0 : d1;
  assign obs_fc    = sel0 ? fc0 : fc1;

  // Capture monitor
  logic [7:0] cap_q[$];
  int         gap_q[$];
  int         err_cyc = 0;
  logic [7:0] err_d = 8'hFF;
  int         idle_run = 1000;
  logic       prev_en = 1'b0;

  always @(negedge clk) begin
    if (obs_en) begin
      cap_q.push_back(obs_d);
      if (!prev_en) gap_q.push_back(idle_run);
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (obs_err) begin
      err_cyc++;
      err_d = obs_d;
    end
    prev_en = obs_en;
  end

  logic [7:0] exp_q[$];

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] cap_at(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 8'hxx;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_exp(input int n, input logic [7:0] base,
                         input bit pad, input int cut);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) begin
      if (i == cut) begin
        exp_q.push_back(8'h00);
        return;
      end
      b = base + 8'(i);
      exp_q.push_back(b);
      c = crc_byte(c, b);
    end
    if (pad) begin
      for (int i = n; i < 60; i++) begin
        exp_q.push_back(8'h00);
        c = crc_byte(c, 8'h00);
      end
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endtask

  task automatic check_frame(input string tag, input int mark);
    int n;
    int bad;
    n = cap_q.size() - mark;
    bad = 0;
    chk({tag, "_len"}, n, exp_q.size());
    foreach (exp_q[i]) begin
      if (cap_at(mark + i) !== exp_q[i]) bad++;
    end
    chk({tag, "_bytes"}, bad, 0);
  endtask

  task automatic send(input int n, input logic [7:0] base,
                      input int gap_after, input bit keep);
    int   idx;
    int   guard;
    logic rdy;
    idx = 0;
    guard = 0;
    s_valid = 1'b1;
    s_data = base;
    s_last = (n == 1);
    while (idx < n && guard < 400) begin
      @(negedge clk);
      rdy = obs_ready;
      @(posedge clk);
      #1;
      guard++;
      if (rdy && s_valid) begin
        idx++;
        if (idx < n) begin
          s_data = base + 8'(idx);
          s_last = (idx == n - 1);
        end
        if (idx == gap_after) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
          s_valid = 1'b1;
        end
      end
    end
    chk("send_accepted", idx, n);
    if (!keep) begin
      s_valid = 1'b0;
      s_last = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (obs_busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_idle", obs_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int e0;
    int guard;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", en1, 0);
    chk("rst_d", d1, 8'h00);
    chk("rst_err", err1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_ready", rdy1, 0);
    chk("rst_fcnt", fc1, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unpadded 9-byte frame "123456789"
    sel0 = 1'b1;
    mark = cap_q.size();
    exp_q.delete();
    add_exp(9, 8'h31, 1'b0, -1);
    send(9, 8'h31, -1, 1'b0);
    wait_idle();
    check_frame("nopad9", mark);
    chk("nopad9_en_cycles", cap_q.size() - mark, 21);
    chk("nopad9_fcs0", cap_at(mark + 17), 8'h26);
    chk("nopad9_fcs1", cap_at(mark + 18), 8'h39);
    chk("nopad9_fcs2", cap_at(mark + 19), 8'hF4);
    chk("nopad9_fcs3", cap_at(mark + 20), 8'hCB);
    chk("nopad9_fcnt", fc0, 16'd1);
    chk("nopad9_ready_idle", rdy0, 0);
    sel0 = 1'b0;
    @(negedge clk);

    // Padded 10-byte frame
    mark = cap_q.size();
    exp_q.delete();
    add_exp(10, 8'hA0, 1'b1, -1);
    send(10, 8'hA0, -1, 1'b0);
    wait_idle();
    check_frame("pad10", mark);
    chk("pad10_first_pad", cap_at(mark + 18), 8'h00);
    chk("pad10_last_pad", cap_at(mark + 67), 8'h00);
    chk("pad10_fcnt", fc1, 16'd1);

    // Back-to-back frames, s_valid never drops
    mark = cap_q.size();
    exp_q.delete();
    add_exp(10, 8'hB0, 1'b1, -1);
    add_exp(10, 8'hC0, 1'b1, -1);
    send(10, 8'hB0, -1, 1'b1);
    send(10, 8'hC0, -1, 1'b0);
    wait_idle();
    check_frame("b2b", mark);
    chk("b2b_ifg", gap_q[gap_q.size() - 1], 12);
    chk("b2b_fcnt", fc1, 16'd3);

    // Underrun after payload byte 5
    mark = cap_q.size();
    e0 = err_cyc;
    exp_q.delete();
    add_exp(10, 8'hD0, 1'b1, 5);
    send(10, 8'hD0, 5, 1'b0);
    wait_idle();
    check_frame("underrun", mark);
    chk("underrun_err_cycles", err_cyc - e0, 1);
    chk("underrun_err_d", err_d, 8'h00);
    chk("underrun_fcnt", fc1, 16'd3);

    mark = cap_q.size();
    exp_q.delete();
    add_exp(10, 8'hE0, 1'b1, -1);
    send(10, 8'hE0, -1, 1'b0);
    wait_idle();
    check_frame("post_underrun", mark);
    chk("post_underrun_fcnt", fc1, 16'd4);

    // Reset during FCS
    mark = cap_q.size();
    send(10, 8'hF0, -1, 1'b0);
    guard = 0;
    @(negedge clk);
    #1;
    while ((cap_q.size() - mark) < 69 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("fcs_reached", cap_q.size() - mark, 69);
    rst_n = 1'b0;
    #1;
    chk("midrst_en", en1, 0);
    chk("midrst_d", d1, 8'h00);
    chk("midrst_busy", busy1, 0);
    chk("midrst_fcnt", fc1, 16'd0);
    repeat (2) @(negedge clk);
    chk("midrst_truncated", cap_q.size() - mark, 69);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    mark = cap_q.size();
    exp_q.delete();
    add_exp(64, 8'h40, 1'b1, -1);
    send(64, 8'h40, -1, 1'b0);
    wait_idle();
    check_frame("post_rst64", mark);
    chk("post_rst64_fcnt", fc1, 16'd1);

    // frame_cnt wrap, using a 1-byte frame
    @(negedge clk);
    force u_dut1.frame_cnt_q = 16'hFFFF;
    #1;
    release u_dut1.frame_cnt_q;
    mark = cap_q.size();
    exp_q.delete();
    add_exp(1, 8'h5A, 1'b1, -1);
    send(1, 8'h5A, -1, 1'b0);
    wait_idle();
    check_frame("wrap1", mark);
    chk("wrap_fcnt", fc1, 16'h0000);

    // Unpadded 1-byte frame
    sel0 = 1'b1;
    @(negedge clk);
    mark = cap_q.size();
    exp_q.delete();
    add_exp(1, 8'h7E, 1'b0, -1);
    send(1, 8'h7E, -1, 1'b0);
    wait_idle();
    check_frame("nopad1", mark);
    chk("nopad1_fcnt", fc0, 16'd1);
    sel0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12: idle cycles after each frame (gm_tx_en=0); legal range 1..63.
REQ-002 SHALL have parameter PAD_EN, default 1: 1 pads payload with 0x00 up to 60 bytes before FCS; 0 disables padding.
REQ-003 SHALL have port clk_125M  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_data  input  8  payload byte from the MAC-side source.
REQ-006 SHALL have port s_valid  input  1  s_data is valid.
REQ-007 SHALL have port s_last  input  1  s_data is the final payload byte of the frame.
REQ-008 SHALL have port s_ready  output  1  framer accepts s_data this cycle.
REQ-009 SHALL have port gm_tx_d  output  8  GMII transmit data toward the gmii_mux.
REQ-010 SHALL have port gm_tx_en  output  1  GMII transmit enable.
REQ-011 SHALL have port gm_tx_err  output  1  GMII transmit error.
REQ-012 SHALL have port busy  output  1  FSM is not in IDLE.
REQ-013 SHALL have port frame_cnt  output  16  count of completed, non-aborted frames; wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG.
REQ-015 IDLE with s_valid=1 at edge N SHALL move to PREAMBLE; 0x55 with gm_tx_en=1 SHALL appear from edge N+1; s_ready=0 in IDLE.
REQ-016 PREAMBLE SHALL output 0x55 for exactly 7 cycles, then SFD SHALL output 0xD5 for 1 cycle.
REQ-017 s_ready SHALL be 1 only in DATA and DRAIN; a byte transfers on s_valid&s_ready.
REQ-018 A byte accepted at edge k SHALL appear on gm_tx_d at edge k+1 (registered, one-cycle latency); all gm_tx_* outputs SHALL be registered.
REQ-019 DATA SHALL count accepted bytes in a 6-bit counter saturating at 60.
REQ-020 On s_last accept: if PAD_EN=1 and count<60, go to PAD; otherwise go to FCS.
REQ-021 PAD SHALL output 0x00 until payload+pad totals exactly 60 bytes, then go to FCS.
REQ-022 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) SHALL cover payload and pad bytes only, not preamble/SFD.
REQ-023 FCS SHALL output the 4 CRC bytes least-significant byte first, then go to IFG.
REQ-024 Underrun (s_valid=0 in DATA) SHALL output gm_tx_d=0x00, gm_tx_en=1, gm_tx_err=1 for one cycle, then go to DRAIN; frame_cnt SHALL NOT increment.
REQ-025 DRAIN SHALL keep gm_tx_en=0 and discard accepted bytes until s_last is accepted, then go to IFG.
REQ-026 IFG SHALL hold gm_tx_en=0, gm_tx_d=0x00 for exactly IFG_CYCLES cycles, then go to IDLE; s_valid is ignored during IFG.
REQ-027 frame_cnt SHALL increment on the cycle the last FCS byte is driven.
REQ-028 A 1-byte frame (s_valid and s_last on the first DATA cycle) SHALL be legal.
REQ-029 gm_tx_err SHALL be 0 outside the underrun cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force: FSM=IDLE; gm_tx_d=0x00; gm_tx_en=0; gm_tx_err=0; s_ready=0; busy=0; frame_cnt=0; CRC register=0xFFFFFFFF; all counters=0.
REQ-031 Reset asserted mid-frame SHALL truncate the frame with no FCS; after release, the next frame SHALL start cleanly from IDLE.

Structure
REQ-032 A shared package gmii_pkg SHALL hold the FSM state typedef and the constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, MIN_PAYLOAD=60, CRC_INIT/CRC_POLY/CRC_XOR.
REQ-033 The CRC SHALL be a sub-module crc32_d8: combinational, 8-bit data in, next 32-bit CRC out.

Verification
REQ-034 PAD_EN=0, payload 0x31..0x39 (9 bytes) -> 7x0x55, 0xD5, 9 data bytes, FCS 0x26 0x39 0xF4 0xCB; 21 gm_tx_en cycles; frame_cnt=1.
REQ-035 PAD_EN=1, 10-byte payload -> 50 pad bytes of 0x00, 60 bytes before FCS; next gm_tx_en rise no earlier than 12 cycles after the last FCS byte.
REQ-036 Drop s_valid after payload byte 5 -> one cycle with gm_tx_err=1, gm_tx_d=0x00; remaining bytes drained through s_last; frame_cnt unchanged; next frame normal.
REQ-037 Assert rst_n=0 during the FCS state -> gm_tx_en=0 immediately; a subsequent 64-byte frame has correct preamble and FCS.
REQ-038 Two back-to-back frames with s_valid held high -> exactly IFG_CYCLES idle cycles between them; frame_cnt wraps 0xFFFF->0x0000 when preloaded by force.
